axi4_lite_slave_regbank: RTL

- AXI4-Lite slave endpoint holding a bank of memory-mapped registers.
- Sits directly downstream of the slave-side AXI4-Lite interface bundle and acts as the responder that consumes master transactions in simulation and FPGA builds.
- Independent write and read FSMs.
- Byte-strobe writes; SLVERR for out-of-range accesses.

---
 rtl/axi4_lite_slave_regbank.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_slave_regbank.sv
// AXI4-Lite slave register bank.
// Independent write and read channels, byte-strobe writes, SLVERR on
// accesses outside the register window.
module axi4_lite_slave_regbank #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int unsigned           STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned           LSB     = $clog2(STRB_W);
  localparam int unsigned           IDX_W   = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] NREGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic                    live;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic                    commit;

  logic [ADDR_WIDTH-1:0]   w_addr_c;
  logic [DATA_WIDTH-1:0]   w_data_c;
  logic [STRB_W-1:0]       w_strb_c;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic [ADDR_WIDTH-1:0]   w_word;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_in_range;

  logic [ADDR_WIDTH-1:0]   r_off;
  logic [ADDR_WIDTH-1:0]   r_word;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_in_range;

  logic                    unused_prot;

  assign unused_prot = ^{awprot, arprot};

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // The later of the two handshakes commits; the earlier one came from the latch.
  assign commit = ((wstate == W_IDLE)      && aw_hs && w_hs) ||
                  ((wstate == W_HAVE_ADDR) && w_hs)          ||
                  ((wstate == W_HAVE_DATA) && aw_hs);

  assign w_addr_c = (wstate == W_HAVE_ADDR) ? awaddr_q : awaddr;
  assign w_data_c = (wstate == W_HAVE_DATA) ? wdata_q  : wdata;
  assign w_strb_c = (wstate == W_HAVE_DATA) ? wstrb_q  : wstrb;

  assign w_off      = w_addr_c - BASE_ADDR;
  assign w_word     = w_off >> LSB;
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_in_range = (w_addr_c >= BASE_ADDR) && (w_word < NREGS_A);

  assign r_off      = araddr - BASE_ADDR;
  assign r_word     = r_off >> LSB;
  assign r_idx      = r_word[IDX_W-1:0];
  assign r_in_range = (araddr >= BASE_ADDR) && (r_word < NREGS_A);

  // Readies stay low until the first clock edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wstate <= W_IDLE;
    else          wstate <= wnext;
  end

  // Write FSM next-state logic.
  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wnext = W_RESP;
        else if (aw_hs)    wnext = W_HAVE_ADDR;
        else if (w_hs)     wnext = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)   wnext = W_RESP;
      W_HAVE_DATA: if (aw_hs)  wnext = W_RESP;
      W_RESP:      if (bready) wnext = W_IDLE;
      default:                 wnext = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from state; bvalid drops with async reset.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        awready = live;
        wready  = live;
      end
      W_HAVE_ADDR: wready  = live;
      W_HAVE_DATA: awready = live;
      W_RESP:      bvalid  = 1'b1;
      default: ;
    endcase
  end

  // Hold whichever of address or data arrives first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs && (wstate == W_IDLE)) awaddr_q <= awaddr;
      if (w_hs && (wstate == W_IDLE)) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  // Write response code captured at commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    bresp <= RESP_OKAY;
    else if (commit) bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  // Register file with per-byte-lane update.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && w_in_range) begin
      for (int unsigned k = 0; k < STRB_W; k++) begin
        if (w_strb_c[k]) regs[w_idx][8*k +: 8] <= w_data_c[8*k +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rstate <= R_IDLE;
    else          rstate <= rnext;
  end

  // Read FSM next-state logic.
  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs)  rnext = R_RESP;
      R_RESP:  if (rready) rnext = R_IDLE;
      default:             rnext = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from state.
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rstate)
      R_IDLE:  arready = live;
      R_RESP:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Read data/response sampled at AR handshake (sees pre-commit register value).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata <= r_in_range ? regs[r_idx] : '0;
      rresp <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule
